// File: rtl/mouse_ps2_pkg.sv
// Shared PS/2 mouse definitions: command/response codes, device IDs,
// IntelliMouse knock rates and the device-side state encoding.
package mouse_ps2_pkg;

   // Host-to-device commands
   localparam logic [7:0] CMD_RESET        = 8'hFF;
   localparam logic [7:0] CMD_SET_DEFAULTS = 8'hF6;
   localparam logic [7:0] CMD_DISABLE      = 8'hF5;
   localparam logic [7:0] CMD_ENABLE       = 8'hF4;
   localparam logic [7:0] CMD_SET_RATE     = 8'hF3;
   localparam logic [7:0] CMD_GET_ID       = 8'hF2;

   // Device-to-host responses
   localparam logic [7:0] RSP_ACK          = 8'hFA;
   localparam logic [7:0] RSP_RESEND       = 8'hFE;
   localparam logic [7:0] RSP_SELF_TEST_OK = 8'hAA;

   // Device IDs
   localparam logic [7:0] ID_STANDARD      = 8'h00;
   localparam logic [7:0] ID_INTELLIMOUSE  = 8'h03;

   // IntelliMouse knock: sample rates 200, 100, 80 in that order
   localparam logic [7:0] KNOCK_RATE_0     = 8'hC8;
   localparam logic [7:0] KNOCK_RATE_1     = 8'h64;
   localparam logic [7:0] KNOCK_RATE_2     = 8'h50;
   localparam logic [7:0] DEFAULT_RATE     = 8'h64;

   // Device state enumeration; 5 bits leaves spare codes that are
   // treated as illegal and recovered to POWERUP.
   typedef logic [4:0] ms_state_t;
   localparam ms_state_t ST_POWERUP      = 5'd0;
   localparam ms_state_t ST_SEND_AA      = 5'd1;
   localparam ms_state_t ST_WAIT_AA      = 5'd2;
   localparam ms_state_t ST_SEND_ID0     = 5'd3;
   localparam ms_state_t ST_WAIT_ID0     = 5'd4;
   localparam ms_state_t ST_IDLE         = 5'd5;
   localparam ms_state_t ST_SEND_RESEND  = 5'd6;
   localparam ms_state_t ST_WAIT_RESEND  = 5'd7;
   localparam ms_state_t ST_SEND_ACK     = 5'd8;
   localparam ms_state_t ST_WAIT_ACK     = 5'd9;
   localparam ms_state_t ST_WAIT_ARG     = 5'd10;
   localparam ms_state_t ST_SEND_ARG_ACK = 5'd11;
   localparam ms_state_t ST_WAIT_ARG_ACK = 5'd12;
   localparam ms_state_t ST_SEND_DEVID   = 5'd13;
   localparam ms_state_t ST_WAIT_DEVID   = 5'd14;
   localparam ms_state_t ST_SEND_PKT     = 5'd15;
   localparam ms_state_t ST_WAIT_PKT     = 5'd16;

   // True for the commands the device acknowledges with FA
   function automatic logic is_known_cmd(input logic [7:0] b);
      return (b == CMD_RESET)   || (b == CMD_SET_DEFAULTS) ||
             (b == CMD_DISABLE) || (b == CMD_ENABLE)       ||
             (b == CMD_SET_RATE)|| (b == CMD_GET_ID);
   endfunction

endpackage

// File: rtl/mouse_device_sm.sv
// Device-side PS/2 mouse controller. Runs the power-up AA/00 report,
// answers host commands, detects the IntelliMouse knock and serialises
// movement packets into 3- or 4-byte reports while streaming.
//
// Handshakes: SEND_BYTE is a one-cycle request with BYTE_TO_SEND held until
// the transmitter's one-cycle BYTE_SENT; BYTE_READY is a one-cycle pulse
// honoured only while READ_ENABLE is high; PKT_VALID is a level that is
// consumed by a one-cycle PKT_ACCEPT pulse, which latches all four fields.
module mouse_device_sm
   import mouse_ps2_pkg::*;
#(
   parameter int SELF_TEST_CYCLES = 500000
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY,
   input  logic       PKT_VALID,
   input  logic [7:0] PKT_STATUS,
   input  logic [7:0] PKT_DX,
   input  logic [7:0] PKT_DY,
   input  logic [7:0] PKT_DZ,
   output logic       PKT_ACCEPT,
   output logic       STREAMING,
   output logic       INTELLIMOUSE,
   output logic [7:0] SAMPLE_RATE,
   output ms_state_t  DEBUG_STATE
);

   localparam int CNT_W = (SELF_TEST_CYCLES > 1) ? $clog2(SELF_TEST_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SELF_TEST_CYCLES - 1);

   ms_state_t        state;
   ms_state_t        state_n;
   logic             state_ok;
   logic             byte_good;
   logic [CNT_W-1:0] st_cnt;
   logic [7:0]       cmd_q;
   logic [7:0]       arg_q;
   logic [23:0]      rate_hist;   // oldest in [23:16], newest in [7:0]
   logic [23:0]      hist_next;
   logic [7:0]       pkt_status_q;
   logic [7:0]       pkt_dx_q;
   logic [7:0]       pkt_dy_q;
   logic [7:0]       pkt_dz_q;
   logic [1:0]       pkt_idx;
   logic [1:0]       pkt_last;

   assign byte_good   = (BYTE_ERROR_CODE == 2'b00);
   assign hist_next   = {rate_hist[15:0], arg_q};
   assign pkt_last    = INTELLIMOUSE ? 2'd3 : 2'd2;
   assign DEBUG_STATE = state;

   // Next-state selection; unknown encodings are flagged for full recovery
   always_comb begin
      state_n  = state;
      state_ok = 1'b1;
      case (state)
         ST_POWERUP:      if (st_cnt == CNT_LAST) state_n = ST_SEND_AA;
         ST_SEND_AA:      state_n = ST_WAIT_AA;
         ST_WAIT_AA:      if (BYTE_SENT) state_n = ST_SEND_ID0;
         ST_SEND_ID0:     state_n = ST_WAIT_ID0;
         ST_WAIT_ID0:     if (BYTE_SENT) state_n = ST_IDLE;
         ST_IDLE: begin
            if (BYTE_READY)
               state_n = (byte_good && is_known_cmd(BYTE_READ)) ? ST_SEND_ACK : ST_SEND_RESEND;
            else if (STREAMING && PKT_VALID)
               state_n = ST_SEND_PKT;
         end
         ST_SEND_RESEND:  state_n = ST_WAIT_RESEND;
         ST_WAIT_RESEND:  if (BYTE_SENT) state_n = ST_IDLE;
         ST_SEND_ACK:     state_n = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (BYTE_SENT) begin
               case (cmd_q)
                  CMD_RESET:    state_n = ST_SEND_AA;
                  CMD_SET_RATE: state_n = ST_WAIT_ARG;
                  CMD_GET_ID:   state_n = ST_SEND_DEVID;
                  default:      state_n = ST_IDLE;
               endcase
            end
         end
         ST_WAIT_ARG:     if (BYTE_READY) state_n = byte_good ? ST_SEND_ARG_ACK : ST_SEND_RESEND;
         ST_SEND_ARG_ACK: state_n = ST_WAIT_ARG_ACK;
         ST_WAIT_ARG_ACK: if (BYTE_SENT) state_n = ST_IDLE;
         ST_SEND_DEVID:   state_n = ST_WAIT_DEVID;
         ST_WAIT_DEVID:   if (BYTE_SENT) state_n = ST_IDLE;
         ST_SEND_PKT:     state_n = ST_WAIT_PKT;
         ST_WAIT_PKT:     if (BYTE_SENT) state_n = (pkt_idx == pkt_last) ? ST_IDLE : ST_SEND_PKT;
         default: begin
            state_n  = ST_POWERUP;
            state_ok = 1'b0;
         end
      endcase
   end

   // State, registered outputs, mode registers and packet latch
   always_ff @(posedge CLK) begin
      if (RESET || !state_ok) begin
         state        <= ST_POWERUP;
         st_cnt       <= '0;
         SEND_BYTE    <= 1'b0;
         BYTE_TO_SEND <= 8'h00;
         READ_ENABLE  <= 1'b0;
         PKT_ACCEPT   <= 1'b0;
         STREAMING    <= 1'b0;
         INTELLIMOUSE <= 1'b0;
         SAMPLE_RATE  <= DEFAULT_RATE;
         rate_hist    <= '0;
         cmd_q        <= 8'h00;
         arg_q        <= 8'h00;
         pkt_status_q <= 8'h00;
         pkt_dx_q     <= 8'h00;
         pkt_dy_q     <= 8'h00;
         pkt_dz_q     <= 8'h00;
         pkt_idx      <= 2'd0;
      end else begin
         state       <= state_n;
         READ_ENABLE <= (state_n == ST_IDLE) || (state_n == ST_WAIT_ARG);
         SEND_BYTE   <= 1'b0;
         PKT_ACCEPT  <= 1'b0;
         case (state)
            ST_POWERUP: st_cnt <= st_cnt + 1'b1;
            ST_SEND_AA: begin
               SEND_BYTE    <= 1'b1;
               BYTE_TO_SEND <= RSP_SELF_TEST_OK;
            end
            ST_SEND_ID0: begin
               SEND_BYTE    <= 1'b1;
               BYTE_TO_SEND <= ID_STANDARD;
            end
            ST_IDLE: begin
               if (BYTE_READY) begin
                  cmd_q <= BYTE_READ;
               end else if (STREAMING && PKT_VALID) begin
                  PKT_ACCEPT   <= 1'b1;
                  pkt_status_q <= PKT_STATUS;
                  pkt_dx_q     <= PKT_DX;
                  pkt_dy_q     <= PKT_DY;
                  pkt_dz_q     <= PKT_DZ;
                  pkt_idx      <= 2'd0;
               end
            end
            ST_SEND_RESEND: begin
               SEND_BYTE    <= 1'b1;
               BYTE_TO_SEND <= RSP_RESEND;
            end
            ST_SEND_ACK, ST_SEND_ARG_ACK: begin
               SEND_BYTE    <= 1'b1;
               BYTE_TO_SEND <= RSP_ACK;
            end
            ST_WAIT_ACK: begin
               // Mode changes take effect once the FA has left the device
               if (BYTE_SENT) begin
                  case (cmd_q)
                     CMD_RESET: begin
                        STREAMING    <= 1'b0;
                        INTELLIMOUSE <= 1'b0;
                        SAMPLE_RATE  <= DEFAULT_RATE;
                        rate_hist    <= '0;
                     end
                     CMD_SET_DEFAULTS: begin
                        SAMPLE_RATE <= DEFAULT_RATE;
                        STREAMING   <= 1'b0;
                     end
                     CMD_DISABLE: STREAMING <= 1'b0;
                     CMD_ENABLE:  STREAMING <= 1'b1;
                     default: ;
                  endcase
               end
            end
            ST_WAIT_ARG: if (BYTE_READY && byte_good) arg_q <= BYTE_READ;
            ST_WAIT_ARG_ACK: begin
               if (BYTE_SENT) begin
                  SAMPLE_RATE <= arg_q;
                  rate_hist   <= hist_next;
                  if (hist_next == {KNOCK_RATE_0, KNOCK_RATE_1, KNOCK_RATE_2})
                     INTELLIMOUSE <= 1'b1;
               end
            end
            ST_SEND_DEVID: begin
               SEND_BYTE    <= 1'b1;
               BYTE_TO_SEND <= INTELLIMOUSE ? ID_INTELLIMOUSE : ID_STANDARD;
            end
            ST_SEND_PKT: begin
               SEND_BYTE <= 1'b1;
               case (pkt_idx)
                  2'd0:    BYTE_TO_SEND <= pkt_status_q;
                  2'd1:    BYTE_TO_SEND <= pkt_dx_q;
                  2'd2:    BYTE_TO_SEND <= pkt_dy_q;
                  default: BYTE_TO_SEND <= pkt_dz_q;
               endcase
            end
            ST_WAIT_PKT: if (BYTE_SENT) pkt_idx <= pkt_idx + 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mouse_device_sm.sv
// Bench for mouse_device_sm: a byte-transmitter responder, a host driver
// and a protocol-level model of the expected response stream and modes.
module tb_mouse_device_sm;

   localparam int N = 20;

   localparam int ACT_NONE  = 0;
   localparam int ACT_RESET = 1;
   localparam int ACT_DEF   = 2;
   localparam int ACT_DIS   = 3;
   localparam int ACT_EN    = 4;
   localparam int ACT_RATE  = 5;
   localparam int AT_CHAIN  = -1;
   localparam int AT_ANY    = -2;

   typedef struct {
      logic [7:0] data;
      int         at;
      int         act;
      logic [7:0] arg;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT = 1'b0;
   logic       READ_ENABLE;
   logic [7:0] BYTE_READ = 8'h00;
   logic [1:0] BYTE_ERROR_CODE = 2'b00;
   logic       BYTE_READY = 1'b0;
   logic       PKT_VALID = 1'b0;
   logic [7:0] PKT_STATUS = 8'h00;
   logic [7:0] PKT_DX = 8'h00;
   logic [7:0] PKT_DY = 8'h00;
   logic [7:0] PKT_DZ = 8'h00;
   logic       PKT_ACCEPT;
   logic       STREAMING;
   logic       INTELLIMOUSE;
   logic [7:0] SAMPLE_RATE;
   logic [4:0] dbg_state;

   mouse_device_sm #(.SELF_TEST_CYCLES(N)) dut (
      .CLK(CLK), .RESET(RESET),
      .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
      .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
      .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
      .PKT_VALID(PKT_VALID), .PKT_STATUS(PKT_STATUS), .PKT_DX(PKT_DX),
      .PKT_DY(PKT_DY), .PKT_DZ(PKT_DZ), .PKT_ACCEPT(PKT_ACCEPT),
      .STREAMING(STREAMING), .INTELLIMOUSE(INTELLIMOUSE),
      .SAMPLE_RATE(SAMPLE_RATE), .DEBUG_STATE(dbg_state)
   );

   // clock / cycle counter
   always #5 CLK = ~CLK;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // scoreboard and model state
   exp_t       exp_q[$];
   logic [7:0] m_hist[$];
   bit         m_stream, m_intelli, m_wait_arg;
   logic [7:0] m_rate = 8'h64;
   int         n_checks = 0;
   int         n_fail = 0;
   bit         chk_en = 0;
   bit         exp_accept = 0;
   bit         tx_busy = 0;
   int         sent_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   function automatic void push(input logic [7:0] d, input int at, input int act, input logic [7:0] arg);
      exp_t e;
      e.data = d; e.at = at; e.act = act; e.arg = arg;
      exp_q.push_back(e);
   endfunction

   function automatic void model_reset();
      m_stream = 0; m_intelli = 0; m_rate = 8'h64; m_hist.delete();
   endfunction

   // Mode changes confirmed by a transmitted FA
   function automatic void apply(input int act, input logic [7:0] arg);
      case (act)
         ACT_RESET: model_reset();
         ACT_DEF:   begin m_rate = 8'h64; m_stream = 0; end
         ACT_DIS:   m_stream = 0;
         ACT_EN:    m_stream = 1;
         ACT_RATE: begin
            m_rate = arg;
            m_hist.push_back(arg);
            if (m_hist.size() > 3) void'(m_hist.pop_front());
            if (m_hist.size() == 3 && m_hist[0] == 8'hC8 && m_hist[1] == 8'h64 && m_hist[2] == 8'h50)
               m_intelli = 1;
         end
         default: ;
      endcase
   endfunction

   // Byte transmitter responder: checks each sent byte against the queue
   initial begin : tx
      exp_t       e;
      logic [7:0] got;
      int         dly;
      bit         aborted;
      forever begin
         @(negedge CLK);
         if (chk_en && SEND_BYTE) begin
            got = BYTE_TO_SEND;
            tx_busy = 1;
            check("read_enable_low_while_sending", READ_ENABLE, 0);
            if (exp_q.size() == 0) begin
               e.act = ACT_NONE; e.arg = 8'h00;
               check("unexpected_send_byte", {24'h0, got}, 32'h100);
            end else begin
               e = exp_q.pop_front();
               check("send_byte_value", got, e.data);
               if (e.at == AT_CHAIN)  check("chained_send_latency", cyc, sent_cyc + 2);
               else if (e.at >= 0)    check("first_send_latency", cyc, e.at);
            end
            dly = $urandom_range(1, 4);
            aborted = 0;
            for (int i = 0; i < dly; i++) begin
               @(negedge CLK);
               if (!chk_en) aborted = 1;
               else if (!aborted) begin
                  check("byte_to_send_stable", BYTE_TO_SEND, got);
                  check("send_byte_single_cycle", SEND_BYTE, 0);
               end
            end
            if (!aborted) begin
               @(posedge CLK); #1;
               BYTE_SENT = 1; sent_cyc = cyc;
               @(posedge CLK); #1;
               BYTE_SENT = 0;
               if (chk_en) apply(e.act, e.arg);
            end
            tx_busy = 0;
         end
      end
   end

   // Per-cycle compare of the mode outputs and packet accept
   always @(negedge CLK) begin
      if (chk_en) begin
         check("streaming", STREAMING, m_stream);
         check("intellimouse", INTELLIMOUSE, m_intelli);
         check("sample_rate", SAMPLE_RATE, m_rate);
         check("pkt_accept", PKT_ACCEPT, exp_accept);
      end
   end

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int k = 0; k < 500; k++) begin
         @(negedge CLK);
         if (exp_q.size() == 0 && !tx_busy && READ_ENABLE) begin ok = 1; break; end
      end
      if (!ok) fail_now("wait_idle");
   endtask

   task automatic send_cmd(input logic [7:0] b, input bit err, input bit with_pkt);
      int first;
      wait_idle();
      step();
      first = cyc + 2;
      if (m_wait_arg) begin
         m_wait_arg = 0;
         if (err) push(8'hFE, first, ACT_NONE, 8'h00);
         else     push(8'hFA, first, ACT_RATE, b);
      end else if (err) begin
         push(8'hFE, first, ACT_NONE, 8'h00);
      end else begin
         case (b)
            8'hFF: begin
               push(8'hFA, first, ACT_RESET, 8'h00);
               push(8'hAA, AT_CHAIN, ACT_NONE, 8'h00);
               push(8'h00, AT_CHAIN, ACT_NONE, 8'h00);
            end
            8'hF6: push(8'hFA, first, ACT_DEF, 8'h00);
            8'hF5: push(8'hFA, first, ACT_DIS, 8'h00);
            8'hF4: push(8'hFA, first, ACT_EN, 8'h00);
            8'hF3: begin push(8'hFA, first, ACT_NONE, 8'h00); m_wait_arg = 1; end
            8'hF2: begin
               push(8'hFA, first, ACT_NONE, 8'h00);
               push(m_intelli ? 8'h03 : 8'h00, AT_CHAIN, ACT_NONE, 8'h00);
            end
            default: push(8'hFE, first, ACT_NONE, 8'h00);
         endcase
      end
      BYTE_READ = b;
      BYTE_ERROR_CODE = err ? 2'($urandom_range(1, 3)) : 2'b00;
      BYTE_READY = 1;
      if (with_pkt) begin
         PKT_VALID = 1; PKT_STATUS = 8'($urandom); PKT_DX = 8'($urandom);
         PKT_DY = 8'($urandom); PKT_DZ = 8'($urandom);
      end
      step();
      BYTE_READY = 0; PKT_VALID = 0; BYTE_ERROR_CODE = 2'b00; BYTE_READ = 8'($urandom);
   endtask

   task automatic send_packet(input logic [7:0] st, input logic [7:0] dx,
                              input logic [7:0] dy, input logic [7:0] dz);
      wait_idle();
      step();
      if (m_stream) begin
         push(st, cyc + 2, ACT_NONE, 8'h00);
         push(dx, AT_CHAIN, ACT_NONE, 8'h00);
         push(dy, AT_CHAIN, ACT_NONE, 8'h00);
         if (m_intelli) push(dz, AT_CHAIN, ACT_NONE, 8'h00);
      end
      PKT_VALID = 1; PKT_STATUS = st; PKT_DX = dx; PKT_DY = dy; PKT_DZ = dz;
      step();
      exp_accept = m_stream;
      PKT_VALID = 0;
      step();
      exp_accept = 0;
   endtask

   task automatic do_reset(input int hold);
      int  rel;
      bit  seen = 0;
      chk_en = 0;
      step();
      RESET = 1; BYTE_READY = 0; PKT_VALID = 0;
      exp_q.delete(); model_reset(); m_wait_arg = 0; exp_accept = 0;
      repeat (hold) step();
      @(negedge CLK);
      check("reset_send_byte", SEND_BYTE, 0);
      check("reset_byte_to_send", BYTE_TO_SEND, 8'h00);
      check("reset_read_enable", READ_ENABLE, 0);
      check("reset_pkt_accept", PKT_ACCEPT, 0);
      check("reset_streaming", STREAMING, 0);
      check("reset_intellimouse", INTELLIMOUSE, 0);
      check("reset_sample_rate", SAMPLE_RATE, 8'h64);
      step();
      RESET = 0; rel = cyc; chk_en = 1;
      push(8'hAA, AT_ANY, ACT_NONE, 8'h00);
      push(8'h00, AT_CHAIN, ACT_NONE, 8'h00);
      for (int k = 0; k < N + 20; k++) begin
         @(negedge CLK);
         if (SEND_BYTE) begin seen = 1; break; end
      end
      if (seen) check("powerup_aa_delay_in_range", (cyc - rel >= N) && (cyc - rel <= N + 2), 1);
      else      fail_now("powerup_aa");
      wait_idle();
      check("read_enable_after_powerup", READ_ENABLE, 1);
   endtask

   task automatic set_rate(input logic [7:0] r);
      send_cmd(8'hF3, 0, 0);
      send_cmd(r, 0, 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int op;
      logic [7:0] b;
      bit ok;

      do_reset(3);

      // enable reporting, 3-byte packet
      send_cmd(8'hF4, 0, 0);
      wait_idle();
      check("streaming_after_f4", STREAMING, 1);
      send_packet(8'h08, 8'h05, 8'hFB, 8'h01);

      // knock 200/100/80, then ID 03 and a 4-byte packet
      set_rate(8'hC8); set_rate(8'h64); set_rate(8'h50);
      send_cmd(8'hF2, 0, 0);
      wait_idle();
      check("intellimouse_after_knock", INTELLIMOUSE, 1);
      check("rate_after_knock", SAMPLE_RATE, 8'h50);
      send_packet(8'h09, 8'h10, 8'hF0, 8'h01);

      // FF clears modes; wrong knock order stays standard
      send_cmd(8'hFF, 0, 0);
      wait_idle();
      check("intellimouse_after_ff", INTELLIMOUSE, 0);
      check("rate_after_ff", SAMPLE_RATE, 8'h64);
      set_rate(8'hC8); set_rate(8'h50); set_rate(8'h64);
      send_cmd(8'hF2, 0, 0);
      wait_idle();
      check("intellimouse_wrong_order", INTELLIMOUSE, 0);

      // non-F3 command inside the knock does not break it
      set_rate(8'hC8); set_rate(8'h64);
      send_cmd(8'hF5, 0, 0);
      set_rate(8'h50);
      wait_idle();
      check("intellimouse_interleaved", INTELLIMOUSE, 1);
      send_cmd(8'hFF, 0, 0);

      // error byte, unknown byte, bad argument
      set_rate(8'h28);
      send_cmd(8'h3C, 1, 0);
      send_cmd(8'hE9, 0, 0);
      send_cmd(8'hF3, 0, 0);
      send_cmd(8'h14, 1, 0);
      wait_idle();
      check("rate_kept_after_bad_arg", SAMPLE_RATE, 8'h28);

      // F6 restores rate, keeps IntelliMouse
      send_cmd(8'hF6, 0, 0);
      wait_idle();
      check("rate_after_f6", SAMPLE_RATE, 8'h64);

      // command wins over a simultaneous packet
      send_cmd(8'hF4, 0, 0);
      send_cmd(8'hF5, 0, 1);
      wait_idle();
      check("streaming_after_f5", STREAMING, 0);

      // byte arriving while a packet is being sent is ignored
      send_cmd(8'hF4, 0, 0);
      send_packet(8'h0A, 8'h01, 8'h02, 8'h03);
      BYTE_READ = 8'hF5; BYTE_READY = 1;
      step();
      BYTE_READY = 0;

      // randomized command/packet mix
      for (int t = 0; t < 60; t++) begin
         op = $urandom_range(0, 9);
         case (op)
            0: send_cmd(8'hF4, 0, 0);
            1: send_cmd(8'hF5, 0, 0);
            2: send_cmd(8'hF6, 0, 0);
            3: send_cmd(8'hF2, 0, 0);
            4: send_cmd(8'($urandom), 0, 0);
            5: send_cmd(8'($urandom), 1, 0);
            6: begin
               case ($urandom_range(0, 3))
                  0: b = 8'hC8;
                  1: b = 8'h64;
                  2: b = 8'h50;
                  default: b = 8'($urandom);
               endcase
               send_cmd(8'hF3, 0, 0);
               send_cmd(b, ($urandom_range(0, 7) == 0), 0);
            end
            default: send_packet(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         endcase
         if (m_wait_arg) send_cmd(8'($urandom), 0, 0);
      end

      // reset while the DX byte is in flight
      send_cmd(8'hF4, 0, 0);
      send_packet(8'h01, 8'h22, 8'h33, 8'h44);
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK);
         if (exp_q.size() <= (m_intelli ? 2 : 1)) begin ok = 1; break; end
      end
      if (!ok) fail_now("wait_dx_send");
      do_reset(2);

      wait_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
